// File: rtl/phy_tx_pkg.sv
// Shared definitions for the two-lane TX link sequencer: FSM states,
// default line symbols and the per-lane output select codes.
package phy_tx_pkg;

  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {
    LINK_DOWN = 2'd0,
    TRAIN     = 2'd1,
    ACTIVE    = 2'd2,
    SKIP      = 2'd3
  } link_state_e;

  localparam logic [7:0] COM_SYM_D = 8'hBC;
  localparam logic [7:0] SKP_SYM_D = 8'h1C;
  localparam logic [7:0] IDL_SYM_D = 8'h7C;

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_DATA,
    SEL_IDL,
    SEL_COM,
    SEL_SKP
  } lane_sel_e;

endpackage

// File: rtl/phy_tx_lane_mux.sv
// Per-lane output register: picks data, filler or an ordered-set symbol
// according to the select code from the link FSM.
module phy_tx_lane_mux
  import phy_tx_pkg::*;
#(
  parameter logic [7:0] COM_SYM = COM_SYM_D,
  parameter logic [7:0] SKP_SYM = SKP_SYM_D,
  parameter logic [7:0] IDL_SYM = IDL_SYM_D
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  lane_sel_e  sel,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out
);

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      unique case (sel)
        SEL_DATA: begin
          // empty slots on an up link are filled with idle rather than gaps
          data_out  <= valid_in ? data_in : IDL_SYM;
          valid_out <= 1'b1;
        end
        SEL_IDL: begin
          data_out  <= IDL_SYM;
          valid_out <= 1'b1;
        end
        SEL_COM: begin
          data_out  <= COM_SYM;
          valid_out <= 1'b1;
        end
        SEL_SKP: begin
          data_out  <= SKP_SYM;
          valid_out <= 1'b1;
        end
        default: begin
          data_out  <= '0;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// Link sequencer for the two-lane TX byte path: COM training, data/idle
// forwarding and periodic COM+SKP insertion with upstream back-pressure.
module phy_tx_link_ctrl
  import phy_tx_pkg::*;
#(
  parameter int         NUM_COM      = 4,
  parameter int         SKP_INTERVAL = 64,
  parameter logic [7:0] COM_SYM      = COM_SYM_D,
  parameter logic [7:0] SKP_SYM      = SKP_SYM_D,
  parameter logic [7:0] IDL_SYM      = IDL_SYM_D
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] lane0_data_in,
  input  logic       lane0_valid_in,
  input  logic [7:0] lane1_data_in,
  input  logic       lane1_valid_in,
  output logic [7:0] lane0_data_out,
  output logic       lane0_valid_out,
  output logic [7:0] lane1_data_out,
  output logic       lane1_valid_out,
  output logic       ready_out,
  output logic       active,
  output logic [1:0] state_out,
  output logic       drop_err
);

  localparam int CCW = (NUM_COM > 1) ? $clog2(NUM_COM) : 1;
  localparam int SCW = $clog2(SKP_INTERVAL);
  localparam logic [CCW-1:0] COM_LAST = CCW'(NUM_COM - 1);
  localparam logic [SCW-1:0] SKP_LAST = SCW'(SKP_INTERVAL - 1);

  link_state_e    state, state_nx;
  logic [CCW-1:0] com_cnt, com_nx;
  logic [SCW-1:0] skp_cnt, skp_nx;
  logic           skp_ph, ph_nx;
  lane_sel_e      sel;

  logic [NUM_LANES-1:0][7:0] din, dout;
  logic [NUM_LANES-1:0]      vin, vout;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state   <= LINK_DOWN;
      com_cnt <= '0;
      skp_cnt <= '0;
      skp_ph  <= 1'b0;
    end else begin
      state   <= state_nx;
      com_cnt <= com_nx;
      skp_cnt <= skp_nx;
      skp_ph  <= ph_nx;
    end
  end

  always_comb begin
    state_nx = state;
    com_nx   = com_cnt;
    skp_nx   = skp_cnt;
    ph_nx    = skp_ph;
    sel      = SEL_ZERO;
    // dropping enable silences the lanes on the very next edge, even mid-SKIP
    if (!enable) begin
      state_nx = LINK_DOWN;
      com_nx   = '0;
      skp_nx   = '0;
      ph_nx    = 1'b0;
    end else begin
      unique case (state)
        LINK_DOWN: begin
          state_nx = TRAIN;
          com_nx   = '0;
        end
        TRAIN: begin
          sel = SEL_COM;
          if (com_cnt == COM_LAST) begin
            state_nx = ACTIVE;
            com_nx   = '0;
            skp_nx   = '0;
          end else begin
            com_nx = com_cnt + 1'b1;
          end
        end
        ACTIVE: begin
          sel = SEL_DATA;
          if (skp_cnt == SKP_LAST) begin
            state_nx = SKIP;
            skp_nx   = '0;
            ph_nx    = 1'b0;
          end else begin
            skp_nx = skp_cnt + 1'b1;
          end
        end
        SKIP: begin
          if (!skp_ph) begin
            sel   = SEL_COM;
            ph_nx = 1'b1;
          end else begin
            sel      = SEL_SKP;
            ph_nx    = 1'b0;
            state_nx = ACTIVE;
            skp_nx   = '0;
          end
        end
        default: state_nx = LINK_DOWN;
      endcase
    end
  end

  assign ready_out = (state == ACTIVE);
  assign active    = (state == ACTIVE) || (state == SKIP);
  assign state_out = state;

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset)                                        drop_err <= 1'b0;
    else if ((lane0_valid_in || lane1_valid_in) && !ready_out) drop_err <= 1'b1;
  end

  assign din = {lane1_data_in, lane0_data_in};
  assign vin = {lane1_valid_in, lane0_valid_in};

  // one select drives every lane so insertion stays lockstep
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    phy_tx_lane_mux #(
      .COM_SYM (COM_SYM),
      .SKP_SYM (SKP_SYM),
      .IDL_SYM (IDL_SYM)
    ) u_mux (
      .clk_4f    (clk_4f),
      .reset     (reset),
      .sel       (sel),
      .data_in   (din[l]),
      .valid_in  (vin[l]),
      .data_out  (dout[l]),
      .valid_out (vout[l])
    );
  end

  assign lane0_data_out  = dout[0];
  assign lane1_data_out  = dout[1];
  assign lane0_valid_out = vout[0];
  assign lane1_valid_out = vout[1];

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// Scoreboard bench: the link is modelled as a cycle index since training
// start mapped onto the repeating COM-train / data-window / COM,SKP timeline.
module tb_phy_tx_link_ctrl;

  localparam int NC = 4;
  localparam int SI = 8;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] lane0_data_in = '0, lane1_data_in = '0;
  logic       lane0_valid_in = 1'b0, lane1_valid_in = 1'b0;
  logic [7:0] lane0_data_out, lane1_data_out;
  logic       lane0_valid_out, lane1_valid_out;
  logic       ready_out, active, drop_err;
  logic [1:0] state_out;

  phy_tx_link_ctrl #(.NUM_COM(NC), .SKP_INTERVAL(SI)) dut (
    .clk_4f          (clk_4f),
    .reset           (reset),
    .enable          (enable),
    .lane0_data_in   (lane0_data_in),
    .lane0_valid_in  (lane0_valid_in),
    .lane1_data_in   (lane1_data_in),
    .lane1_valid_in  (lane1_valid_in),
    .lane0_data_out  (lane0_data_out),
    .lane0_valid_out (lane0_valid_out),
    .lane1_data_out  (lane1_data_out),
    .lane1_valid_out (lane1_valid_out),
    .ready_out       (ready_out),
    .active          (active),
    .state_out       (state_out),
    .drop_err        (drop_err)
  );

  always #5 clk_4f = ~clk_4f;

  int cyc = 0;
  always @(posedge clk_4f) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d0;
    logic [7:0] d1;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: t<0 link down, else cycles since training began
  int t = -1;
  bit m_drop = 1'b0;

  // 0 down, 1 training, 2 data window, 3 skip COM, 4 skip SKP
  function automatic int kind(input int tt);
    int p;
    if (tt < 0) return 0;
    if (tt < NC) return 1;
    p = (tt - NC) % (SI + 2);
    if (p < SI) return 2;
    return (p == SI) ? 3 : 4;
  endfunction

  task automatic cycle(input bit en, input bit v0, input bit v1,
                       input logic [7:0] a, input logic [7:0] b);
    int   k;
    exp_t e;
    @(negedge clk_4f);
    k = kind(t);
    chk("ready_out", int'(ready_out), int'(k == 2));
    chk("active", int'(active), int'(k >= 2));
    chk("state_out", int'(state_out), (k >= 3) ? 3 : k);
    chk("drop_err", int'(drop_err), int'(m_drop));
    enable = en;
    lane0_valid_in = v0; lane0_data_in = a;
    lane1_valid_in = v1; lane1_data_in = b;
    if (en && k != 0) begin
      e.cyc = cyc + 1;
      if (k == 2) begin
        e.d0 = v0 ? a : 8'h7C;
        e.d1 = v1 ? b : 8'h7C;
      end else begin
        e.d0 = (k == 4) ? 8'h1C : 8'hBC;
        e.d1 = e.d0;
      end
      q.push_back(e);
    end
    if ((v0 || v1) && k != 2) m_drop = 1'b1;
    t = !en ? -1 : (t < 0 ? 0 : t + 1);
  endtask

  // monitor: pops an expectation whenever the DUT presents valid bytes
  always @(negedge clk_4f) begin
    exp_t e;
    if (reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_output: got none expected %0h/%0h at cycle %0d",
                 q[0].d0, q[0].d1, q[0].cyc);
        void'(q.pop_front());
      end
      chk("lockstep_valid", int'(lane1_valid_out), int'(lane0_valid_out));
      if (lane0_valid_out) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h/%0h expected nothing (cycle %0d)",
                   lane0_data_out, lane1_data_out, cyc);
        end else begin
          e = q.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("lane0_data", int'(lane0_data_out), int'(e.d0));
          chk("lane1_data", int'(lane1_data_out), int'(e.d1));
        end
      end else begin
        chk("idle_data_zero", int'({lane1_data_out, lane0_data_out}), 0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, int'({lane1_data_out, lane0_data_out, lane1_valid_out,
                              lane0_valid_out, ready_out, active, drop_err}), 0);
    chk({tag, "_state"}, int'(state_out), 0);
  endtask

  int nb;
  initial begin
    // reset held low, then idle with enable low
    repeat (3) @(negedge clk_4f);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (10) cycle(0, 0, 0, 8'h00, 8'h00);

    // training then first data slots: lane0 data, lane1 idle
    repeat (5) cycle(1, 0, 0, 8'h00, 8'h00);
    cycle(1, 1, 0, 8'h11, 8'hEE);
    cycle(1, 1, 0, 8'h22, 8'hEE);

    // stream bytes on lane0 through SKP windows, honouring ready
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (kind(t) == 2) begin
        cycle(1, 1, 0, 8'(nb), 8'h00);
        nb++;
      end else begin
        cycle(1, 0, 0, 8'h00, 8'h00);
      end
    end

    // lane1 byte offered during SKIP is dropped
    while (kind(t) != 3) cycle(1, 0, 0, 8'h00, 8'h00);
    cycle(1, 0, 1, 8'h00, 8'hA5);
    repeat (3) cycle(1, 0, 0, 8'h00, 8'h00);

    // abort training after two COMs, then retrain fully
    repeat (2) cycle(0, 0, 0, 8'h00, 8'h00);
    repeat (3) cycle(1, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 8'h00, 8'h00);
    repeat (8) cycle(1, 0, 0, 8'h00, 8'h00);

    // abort in the middle of SKIP
    while (kind(t) != 4) cycle(1, 0, 0, 8'h00, 8'h00);
    cycle(0, 0, 0, 8'h00, 8'h00);
    repeat (2) cycle(0, 0, 0, 8'h00, 8'h00);

    // randomized traffic with occasional link drops
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 50) != 0, $urandom % 2, $urandom % 2,
            8'($urandom), 8'($urandom));

    // async reset mid-ACTIVE, observed before the next clock edge
    while (kind(t) != 2) cycle(1, 0, 0, 8'h00, 8'h00);
    @(negedge clk_4f);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    q.delete();
    t = -1;
    m_drop = 1'b0;
    enable = 1'b0;
    lane0_valid_in = 1'b0;
    lane1_valid_in = 1'b0;
    @(negedge clk_4f);
    chk_all_zero("reset_hold");
    #1 reset = 1'b1;

    for (int i = 0; i < 60; i++)
      cycle(1, $urandom % 2, $urandom % 2, 8'($urandom), 8'($urandom));
    repeat (3) cycle(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk_4f);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
